// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the IF stage and its boot loader.
package pipeline_pkg;

    // Fetch-side control states: streaming a program in, then fetching from it.
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

    // addi x0, x0, 0 -- the canonical RISC-V no-op.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_imem_loader.sv
// Boot loader FSM: streams program words into instruction memory over a
// valid/ready port, then hands the memory address port over to the PC.
module imem_loader import pipeline_pkg::*; #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    input  logic          go,
    input  logic [AW-1:0] pc_addr,
    output logic          imem_wr,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    output logic          running
);

    fetch_state_e  state;
    logic [AW-1:0] load_cnt;
    logic          handshake;

    // In LOAD the loader is always ready, so every valid word is a handshake.
    assign handshake = (state == LOAD) && load_valid;

    // Load sequencing: count accepted words and leave LOAD on last word, full memory, or go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            load_cnt <= '0;
        end else if (state == LOAD) begin
            if (handshake) begin
                load_cnt <= load_cnt + 1'b1;
                if (load_last || (load_cnt == {AW{1'b1}})) begin
                    state <= RUN;
                end
            end else if (go) begin
                state <= RUN;
            end
        end
    end

    // Memory port ownership: loader counter while loading, fetch PC while running.
    always_comb begin
        running    = (state == RUN);
        load_ready = (state == LOAD);
        imem_wr    = handshake;
        imem_addr  = pc_addr;
        imem_wdata = '0;
        if (state == LOAD) begin
            imem_addr  = load_cnt;
            imem_wdata = load_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches from combinational instruction memory and
// registers the result into IF/ID. A boot loader fills memory before fetch starts.
module instr_fetch import pipeline_pkg::*; #(
    parameter int          AW       = 9,
    parameter int          DW       = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    input  logic          go,
    output logic          imem_wr,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    input  logic [DW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          flush,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          if_id_valid,
    output logic [31:0]   if_id_pc,
    output logic [31:0]   if_id_pc_plus4,
    output logic [DW-1:0] if_id_instr,
    output logic          running,
    output logic          misalign_err
);

    logic [31:0] pc;
    if_id_t      if_id_q;

    imem_loader #(
        .AW(AW),
        .DW(DW)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .go         (go),
        .pc_addr    (pc[AW+1:2]),
        .imem_wr    (imem_wr),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .running    (running)
    );

    // PC and IF/ID update: redirect beats flush beats stall beats a normal advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            if_id_q      <= '{valid: 1'b0, pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR};
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (running) begin
                if (redirect_valid) begin
                    pc            <= {redirect_pc[31:2], 2'b00};
                    if_id_q.valid <= 1'b0;
                    misalign_err  <= (redirect_pc[1:0] != 2'b00);
                end else if (flush) begin
                    if_id_q.valid <= 1'b0;
                end else if (!stall) begin
                    if_id_q.valid    <= 1'b1;
                    if_id_q.pc       <= pc;
                    if_id_q.pc_plus4 <= pc + 32'd4;
                    if_id_q.instr    <= imem_rdata;
                    pc               <= pc + 32'd4;
                end
            end
        end
    end

    assign if_id_valid    = if_id_q.valid;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_instr    = if_id_q.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural instruction memory.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        go;
    logic        imem_wr;
    logic [8:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        running;
    logic        misalign_err;

    int checks;
    int failures;

    logic [31:0] prog [0:3];
    logic [31:0] mem  [0:511];

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .load_last      (load_last),
        .go             (go),
        .imem_wr        (imem_wr),
        .imem_addr      (imem_addr),
        .imem_wdata     (imem_wdata),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .running        (running),
        .misalign_err   (misalign_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-write, combinational-read instruction memory.
    always @(posedge clk) begin
        if (imem_wr) mem[imem_addr] <= imem_wdata;
    end
    assign imem_rdata = mem[imem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load_valid     = 1'b0;
        load_data      = 32'h0;
        load_last      = 1'b0;
        go             = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    // Assert reset mid-cycle, check reset values, release away from the edge.
    task automatic test_reset();
        step();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_id_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", if_id_valid); end
        checks++;
        if (if_id_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", if_id_pc); end
        checks++;
        if (if_id_pc_plus4 !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc4 got=%h exp=0", if_id_pc_plus4); end
        checks++;
        if (if_id_instr !== 32'h0000_0013) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=00000013", if_id_instr); end
        checks++;
        if (misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign got=%0b exp=0", misalign_err); end
        checks++;
        if (running !== 1'b0 || load_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_state running=%0b ready=%0b exp running=0 ready=1", running, load_ready); end
        checks++;
        if (imem_addr !== 9'd0 || imem_wr !== 1'b0) begin failures++; $display("[TB] FAIL reset_port addr=%0d wr=%0b exp addr=0 wr=0", imem_addr, imem_wr); end
        step();
        rst_n = 1'b1;
    endtask

    // Stream a 4-word program, then fetch it back in order.
    task automatic test_load_run();
        for (int k = 0; k < 4; k++) begin
            load_valid = 1'b1;
            load_data  = prog[k];
            load_last  = (k == 3);
            #1;
            checks++;
            if (imem_wr !== 1'b1 || imem_addr !== k[8:0] || imem_wdata !== prog[k] || running !== 1'b0) begin
                failures++;
                $display("[TB] FAIL load_write k=%0d wr=%0b addr=%0d data=%h run=%0b exp wr=1 addr=%0d data=%h run=0",
                         k, imem_wr, imem_addr, imem_wdata, running, k, prog[k]);
            end
            step();
        end
        clear_inputs();
        #1;
        checks++;
        if (running !== 1'b1 || load_ready !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 9'd0) begin
            failures++;
            $display("[TB] FAIL enter_run run=%0b ready=%0b valid=%0b addr=%0d exp run=1 ready=0 valid=0 addr=0",
                     running, load_ready, if_id_valid, imem_addr);
        end
        for (int j = 0; j < 4; j++) begin
            step();
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4*j) || if_id_instr !== prog[j] || if_id_pc_plus4 !== 32'(4*j+4)) begin
                failures++;
                $display("[TB] FAIL fetch_seq j=%0d valid=%0b pc=%h pc4=%h instr=%h exp valid=1 pc=%h pc4=%h instr=%h",
                         j, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, 4*j, 4*j+4, prog[j]);
            end
        end
    endtask

    // go with a non-final handshake keeps loading; go alone starts fetch.
    task automatic test_go_skip();
        test_reset();
        load_valid = 1'b1;
        load_data  = prog[0];
        go         = 1'b1;
        step();
        load_valid = 1'b0;
        #1;
        checks++;
        if (running !== 1'b0 || imem_addr !== 9'd1) begin
            failures++;
            $display("[TB] FAIL go_with_hs run=%0b addr=%0d exp run=0 addr=1", running, imem_addr);
        end
        step();
        go = 1'b0;
        #1;
        checks++;
        if (running !== 1'b1 || if_id_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL go_run run=%0b valid=%0b exp run=1 valid=0", running, if_id_valid);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h4 || if_id_instr !== prog[0]) begin
            failures++;
            $display("[TB] FAIL go_first valid=%0b pc=%h pc4=%h instr=%h exp valid=1 pc=0 pc4=4 instr=%h",
                     if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, prog[0]);
        end
    endtask

    // Hold stall for three cycles with pc=8, then release.
    task automatic test_stall();
        step();
        checks++;
        if (if_id_pc !== 32'h4 || imem_addr !== 9'd2) begin
            failures++;
            $display("[TB] FAIL pre_stall pc=%h addr=%0d exp pc=4 addr=2", if_id_pc, imem_addr);
        end
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (if_id_pc !== 32'h4 || imem_addr !== 9'd2 || if_id_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stall_hold c=%0d pc=%h addr=%0d valid=%0b exp pc=4 addr=2 valid=1", c, if_id_pc, imem_addr, if_id_valid);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (if_id_pc !== 32'h8 || if_id_instr !== prog[2]) begin
            failures++;
            $display("[TB] FAIL stall_release pc=%h instr=%h exp pc=8 instr=%h", if_id_pc, if_id_instr, prog[2]);
        end
    endtask

    // Redirect wins over stall and squashes IF/ID while keeping old payload.
    task automatic test_redirect_stalled();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'h8 || imem_addr !== 9'd16 || misalign_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL redirect_stalled valid=%0b pc=%h addr=%0d mis=%0b exp valid=0 pc=8 addr=16 mis=0",
                     if_id_valid, if_id_pc, imem_addr, misalign_err);
        end
        stall = 1'b0;
        step();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40 || if_id_pc_plus4 !== 32'h44) begin
            failures++;
            $display("[TB] FAIL redirect_target valid=%0b pc=%h pc4=%h exp valid=1 pc=40 pc4=44", if_id_valid, if_id_pc, if_id_pc_plus4);
        end
    endtask

    // Misaligned redirect aligns the PC and pulses misalign_err once.
    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (misalign_err !== 1'b1 || imem_addr !== 9'd16 || if_id_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL misalign_pulse mis=%0b addr=%0d valid=%0b exp mis=1 addr=16 valid=0", misalign_err, imem_addr, if_id_valid);
        end
        step();
        checks++;
        if (misalign_err !== 1'b0 || if_id_pc !== 32'h40 || if_id_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL misalign_after mis=%0b pc=%h valid=%0b exp mis=0 pc=40 valid=1", misalign_err, if_id_pc, if_id_valid);
        end
    endtask

    // Flush squashes IF/ID without moving the PC (pc=0x44 here).
    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || imem_addr !== 9'd17 || if_id_pc !== 32'h40) begin
            failures++;
            $display("[TB] FAIL flush_squash valid=%0b addr=%0d pc=%h exp valid=0 addr=17 pc=40", if_id_valid, imem_addr, if_id_pc);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h44) begin
            failures++;
            $display("[TB] FAIL flush_resume valid=%0b pc=%h exp valid=1 pc=44", if_id_valid, if_id_pc);
        end
    endtask

    // Fill all 512 words without load_last, then check fetch and address wrap.
    task automatic test_full_load();
        int bad;
        test_reset();
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA500_0000 | 32'(i);
            #1;
            if (imem_addr !== i[8:0] || imem_wr !== 1'b1 || running !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL full_stream bad_cycles=%0d exp 0", bad);
        end
        checks++;
        if (running !== 1'b1 || load_ready !== 1'b0 || imem_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_run run=%0b ready=%0b wr=%0b exp run=1 ready=0 wr=0", running, load_ready, imem_wr);
        end
        load_valid = 1'b0;
        step();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'hA500_0000) begin
            failures++;
            $display("[TB] FAIL full_first valid=%0b pc=%h instr=%h exp valid=1 pc=0 instr=a5000000", if_id_valid, if_id_pc, if_id_instr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7FC;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (if_id_pc !== 32'h7FC || if_id_instr !== 32'hA500_01FF || imem_addr !== 9'd0) begin
            failures++;
            $display("[TB] FAIL addr_wrap pc=%h instr=%h addr=%0d exp pc=7fc instr=a50001ff addr=0", if_id_pc, if_id_instr, imem_addr);
        end
    endtask

    // Reset in the middle of a stream returns to LOAD immediately.
    task automatic test_reset_midload();
        test_reset();
        for (int i = 0; i < 100; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h5A00_0000 | 32'(i);
            step();
        end
        #1;
        checks++;
        if (imem_addr !== 9'd100) begin
            failures++;
            $display("[TB] FAIL midload_cnt addr=%0d exp 100", imem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 9'd0 || running !== 1'b0 || if_id_valid !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midload_reset addr=%0d run=%0b valid=%0b ready=%0b exp addr=0 run=0 valid=0 ready=1",
                     imem_addr, running, if_id_valid, load_ready);
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prog[0]  = 32'h0050_0093;
        prog[1]  = 32'h0060_0113;
        prog[2]  = 32'h0020_81B3;
        prog[3]  = 32'h0000_0013;
        rst_n    = 1'b1;
        clear_inputs();
        test_reset();
        test_load_run();
        test_go_skip();
        test_stall();
        test_redirect_stalled();
        test_misalign();
        test_flush();
        test_full_load();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- IF stage of the 5-stage pipeline, directly upstream of the instruction memory.
- Owns the PC, drives the instruction memory address/write ports, and registers the fetched word into the IF/ID pipeline register.
- Includes a boot loader FSM that streams a program into instruction memory over a valid/ready port before fetch starts.
- Memory read is combinational (same-cycle rdata); this block provides the only register stage.

Parameters:
AW, 9, instruction memory word-address width (2**AW words)
DW, 32, instruction word width
RESET_PC, 32'h0000_0000, byte-address PC value at reset and on entering RUN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  loader word valid
load_ready  out  1  loader word accepted
load_data  in  DW  program word
load_last  in  1  final word of program
go  in  1  skip/finish loading, start fetch
imem_wr  out  1  instruction memory write enable
imem_addr  out  AW  instruction memory word address
imem_wdata  out  DW  instruction memory write data
imem_rdata  in  DW  instruction memory read data (combinational)
stall  in  1  hold PC and IF/ID
flush  in  1  squash IF/ID contents
redirect_valid  in  1  branch/jump taken
redirect_pc  in  32  target byte address
if_id_valid  out  1  IF/ID holds a live instruction
if_id_pc  out  32  PC of the IF/ID instruction
if_id_pc_plus4  out  32  if_id_pc + 4
if_id_instr  out  DW  fetched instruction
running  out  1  FSM in RUN
misalign_err  out  1  one-cycle pulse on misaligned redirect

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, load_cnt=0, pc=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=32'h0000_0013 (NOP).
  - misalign_err=0.
  - Reset mid-load or mid-run discards everything and returns to LOAD with load_cnt=0.
- FSM states: LOAD, RUN.
- LOAD state:
  - load_ready=1.
  - imem_addr=load_cnt, imem_wdata=load_data, imem_wr=load_valid (handshake = load_valid & load_ready).
  - On each handshake, load_cnt increments by 1.
  - Handshake with load_last=1, or with load_cnt==2**AW-1 (memory full): go to RUN next cycle.
  - Otherwise, go=1 with load_valid=0: go to RUN.
  - go=1 together with a handshake: the word is written; state goes to RUN only if last/full.
  - stall, flush and redirect are ignored. if_id_valid stays 0. pc stays RESET_PC.
- RUN state:
  - load_ready=0, imem_wr=0, imem_addr=pc[AW+1:2].
  - pc bits above AW+1 are ignored for addressing (address wraps modulo memory size).
  - RUN is left only by reset.
- RUN per-cycle priority (highest first):
  1. redirect_valid: pc <= {redirect_pc[31:2],2'b00}; if_id_valid <= 0, even while stalled. misalign_err <= (redirect_pc[1:0]!=0) for one cycle.
  2. flush: if_id_valid <= 0; pc holds.
  3. stall: pc and all if_id_* hold.
  4. Advance:
     - if_id_valid <= 1, if_id_pc <= pc, if_id_pc_plus4 <= pc+4, if_id_instr <= imem_rdata.
     - pc <= pc+4, wrapping modulo 2**32.
- Fetch latency: the instruction at pc appears on if_id_* at the next rising edge.
- The first RUN cycle fetches RESET_PC, so if_id_valid=1 on the second RUN edge.
- Squashed entries (if_id_valid=0) keep their previous pc/instr values; downstream must qualify with valid.
- running = (state==RUN), decoded combinationally from state.

Decomposition:
- pipeline_pkg additions:
  - fetch_state_e enum {LOAD, RUN}
  - if_id_t struct {valid, pc, pc_plus4, instr}
  - NOP_INSTR constant 32'h0000_0013
  - RESET_PC default constant
- One natural sub-module: imem_loader, containing the LOAD/RUN FSM, load_cnt, the handshake, and the imem write-port mux.
- instr_fetch keeps the PC and the IF/ID register.

Test Plan:
- Reset, then stream 4 words 0x00500093, 0x00600113, 0x002081B3, 0x00000013 (last on 4th) -> imem writes at addr 0..3; running=1 one cycle after the 4th handshake; if_id_pc sequence 0,4,8,12 with matching instrs.
- Reset, then go=1 with no load_valid -> RUN next cycle; first if_id_valid=1 with if_id_pc=0, if_id_pc_plus4=4.
- RUN, stall held 3 cycles at pc=8 -> if_id_pc stays 4 and pc stays 8; on release, if_id_pc=8 next edge.
- redirect_valid with redirect_pc=0x40 while stall=1 -> if_id_valid=0 next edge; then if_id_pc=0x40.
- redirect_pc=0x42 -> pc becomes 0x40 and misalign_err=1 for exactly one cycle.
- Stream 2**AW=512 words without load_last -> RUN after word 511, load_ready=0; rst_n asserted mid-stream at word 100 -> load_cnt=0, if_id_valid=0, state LOAD immediately.
